// File: rtl/pipeline_if.sv
// Instruction-fetch stage: single-outstanding imem handshake feeding the IF/ID register.
// Define IF_FETCH_CNT_EN to add fetch_cnt_IF, a wrapping count of valid IF/ID loads.
module pipeline_if (
    input  logic        clk_IF,
    input  logic        rst_IF,
    input  logic        stall_IF,
    input  logic        flush_IF,
    input  logic        redirect_IF,
    input  logic [31:0] redirect_PC_IF,
    output logic        imem_req_IF,
    output logic [31:0] imem_addr_IF,
    input  logic        imem_ready_IF,
    input  logic [31:0] imem_data_IF,
    output logic [31:0] Inst_out_IF,
    output logic [31:0] PC_out_IF,
    output logic        valid_out_IF
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_IF
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_buf, hold_buf_nxt;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic        load_valid;

    always_ff @(posedge clk_IF) begin
        if (rst_IF) begin
            state    <= REQ;
            pc       <= '0;
            hold_buf <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_buf_nxt = hold_buf;
        deliver      = 1'b0;
        deliver_inst = hold_buf;
        case (state)
            REQ: begin
                if (redirect_IF) begin
                    pc_nxt    = redirect_PC_IF;
                    state_nxt = DROP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_ready_IF) begin
                    if (redirect_IF) begin
                        pc_nxt    = redirect_PC_IF;
                        state_nxt = REQ;
                    end else if (stall_IF) begin
                        hold_buf_nxt = imem_data_IF;
                        state_nxt    = HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_inst = imem_data_IF;
                        pc_nxt       = pc + 32'd4;
                        state_nxt    = REQ;
                    end
                end else if (redirect_IF) begin
                    pc_nxt    = redirect_PC_IF;
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (redirect_IF) begin
                    pc_nxt    = redirect_PC_IF;
                    state_nxt = REQ;
                end else if (!stall_IF) begin
                    deliver   = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                // A redirect coinciding with the stale response keeps the new target for the next fetch.
                if (redirect_IF)
                    pc_nxt = redirect_PC_IF;
                if (imem_ready_IF)
                    state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    assign imem_req_IF  = (state == REQ);
    assign imem_addr_IF = pc;
    assign load_valid   = deliver && !flush_IF && !stall_IF;

    always_ff @(posedge clk_IF) begin
        if (rst_IF) begin
            Inst_out_IF  <= NOP;
            PC_out_IF    <= '0;
            valid_out_IF <= 1'b0;
        end else if (flush_IF) begin
            Inst_out_IF  <= NOP;
            valid_out_IF <= 1'b0;
        end else if (!stall_IF) begin
            if (load_valid) begin
                Inst_out_IF  <= deliver_inst;
                PC_out_IF    <= pc;
                valid_out_IF <= 1'b1;
            end else begin
                Inst_out_IF  <= NOP;
                valid_out_IF <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_CNT_EN
    always_ff @(posedge clk_IF) begin
        if (rst_IF)
            fetch_cnt_IF <= '0;
        else if (load_valid)
            fetch_cnt_IF <= fetch_cnt_IF + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipeline_if.sv
// Self-checking bench for pipeline_if: imem responder, event log and an instruction-stream reference model.
// Define IF_FETCH_CNT_EN to also exercise fetch_cnt_IF.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        rst_IF = 1'b1;
    logic        stall_IF = 1'b0;
    logic        flush_IF = 1'b0;
    logic        redirect_IF = 1'b0;
    logic [31:0] redirect_PC_IF = '0;
    logic        imem_req_IF;
    logic [31:0] imem_addr_IF;
    logic        imem_ready_IF = 1'b0;
    logic [31:0] imem_data_IF = '0;
    logic [31:0] Inst_out_IF;
    logic [31:0] PC_out_IF;
    logic        valid_out_IF;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_IF;
`endif

    pipeline_if dut (
        .clk_IF         (clk),
        .rst_IF         (rst_IF),
        .stall_IF       (stall_IF),
        .flush_IF       (flush_IF),
        .redirect_IF    (redirect_IF),
        .redirect_PC_IF (redirect_PC_IF),
        .imem_req_IF    (imem_req_IF),
        .imem_addr_IF   (imem_addr_IF),
        .imem_ready_IF  (imem_ready_IF),
        .imem_data_IF   (imem_data_IF),
        .Inst_out_IF    (Inst_out_IF),
        .PC_out_IF      (PC_out_IF),
        .valid_out_IF   (valid_out_IF)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt_IF   (fetch_cnt_IF)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // kind 0 = request (a = addr), 1 = delivery (a = pc, b = inst), 2 = redirect (a = target)
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } ev_t;
    ev_t evq[$];
    int  cyc = 0;

    int          lat_fixed = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] p_addr = '0;
    int          overlap_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h4)
            return 32'h0050_0093;
        return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0003;
    endfunction

    // Memory: one response strobe lat cycles after each observed request.
    always @(negedge clk) begin
        if (rst_IF) begin
            pend          = 1'b0;
            imem_ready_IF = 1'b0;
        end else begin
            imem_ready_IF = 1'b0;
            imem_data_IF  = $urandom;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    imem_ready_IF = 1'b1;
                    imem_data_IF  = mem_word(p_addr);
                    pend          = 1'b0;
                end
            end
            if (imem_req_IF) begin
                if (pend)
                    overlap_err++;
                pend   = 1'b1;
                p_addr = imem_addr_IF;
                cnt    = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(3, 1));
            end
        end
    end

    logic        c_rst, c_stall, c_flush, c_redir;
    logic [31:0] c_tgt;
    always begin
        @(posedge clk);
        c_rst = rst_IF; c_stall = stall_IF; c_flush = flush_IF;
        c_redir = redirect_IF; c_tgt = redirect_PC_IF;
        @(negedge clk);
        cyc++;
        if (!c_rst) begin
            if (c_redir)
                evq.push_back('{kind: 2, a: c_tgt, b: 32'h0, cyc: cyc});
            if (valid_out_IF && !c_stall && !c_flush)
                evq.push_back('{kind: 1, a: PC_out_IF, b: Inst_out_IF, cyc: cyc});
        end
        if (!rst_IF && imem_req_IF)
            evq.push_back('{kind: 0, a: imem_addr_IF, b: 32'h0, cyc: cyc});
    end

    function automatic int nth_idx(input int kind, input int n);
        int k = 0;
        foreach (evq[i])
            if (evq[i].kind == kind) begin
                if (k == n) return i;
                k++;
            end
        return -1;
    endfunction

    function automatic logic [31:0] ev_a(input int kind, input int n);
        int i = nth_idx(kind, n);
        return (i < 0) ? 32'hxxxx_xxxx : evq[i].a;
    endfunction

    function automatic logic [31:0] ev_b(input int kind, input int n);
        int i = nth_idx(kind, n);
        return (i < 0) ? 32'hxxxx_xxxx : evq[i].b;
    endfunction

    function automatic int ev_cyc(input int kind, input int n);
        int i = nth_idx(kind, n);
        return (i < 0) ? -1000 : evq[i].cyc;
    endfunction

    function automatic int n_of(input int kind);
        int k = 0;
        foreach (evq[i])
            if (evq[i].kind == kind) k++;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_IF = 1'b1; stall_IF = 1'b0; flush_IF = 1'b0;
        redirect_IF = 1'b0; redirect_PC_IF = '0;
        tick();
        tick();
        evq.delete();
        overlap_err = 0;
        rst_IF = 1'b0;
    endtask

    task automatic test_reset();
        lat_fixed = 1;
        tick();
        rst_IF = 1'b1; stall_IF = 1'b0; flush_IF = 1'b0; redirect_IF = 1'b0;
        tick();
        tick();
        n_checks++; if (imem_req_IF !== 1'b1) $display("FAIL reset_req: got %b want 1", imem_req_IF); else n_pass++;
        n_checks++; if (imem_addr_IF !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imem_addr_IF); else n_pass++;
        n_checks++; if (valid_out_IF !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out_IF); else n_pass++;
        n_checks++; if (Inst_out_IF !== 32'h13) $display("FAIL reset_inst: got %h want 00000013", Inst_out_IF); else n_pass++;
        n_checks++; if (PC_out_IF !== 32'h0) $display("FAIL reset_pc_out: got %h want 00000000", PC_out_IF); else n_pass++;
        rst_IF = 1'b0;
    endtask

    task automatic test_sequential();
        lat_fixed = 1;
        do_reset();
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ev_a(0, i) !== 32'(i * 4)) $display("FAIL seq_req_addr%0d: got %h want %h", i, ev_a(0, i), 32'(i * 4)); else n_pass++;
            n_checks++; if (ev_a(1, i) !== 32'(i * 4)) $display("FAIL seq_pc_out%0d: got %h want %h", i, ev_a(1, i), 32'(i * 4)); else n_pass++;
            n_checks++; if (ev_b(1, i) !== mem_word(32'(i * 4))) $display("FAIL seq_inst%0d: got %h want %h", i, ev_b(1, i), mem_word(32'(i * 4))); else n_pass++;
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++; if (ev_cyc(0, i) - ev_cyc(0, i - 1) !== 2) $display("FAIL seq_req_spacing%0d: got %0d want 2", i, ev_cyc(0, i) - ev_cyc(0, i - 1)); else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        int rel_cyc;
        lat_fixed = 1;
        do_reset();
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (imem_req_IF && imem_addr_IF == 32'h4) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL stall_wait_req4: got %b want 1", found); else n_pass++;
        tick();
        stall_IF = 1'b1;
        tick();
        tick();
        n_checks++; if (imem_req_IF !== 1'b0) $display("FAIL stall_no_req: got %b want 0", imem_req_IF); else n_pass++;
        tick();
        stall_IF = 1'b0;
        rel_cyc = cyc;
        repeat (8) tick();
        n_checks++; if (ev_a(1, 1) !== 32'h4) $display("FAIL stall_pc_out: got %h want 00000004", ev_a(1, 1)); else n_pass++;
        n_checks++; if (ev_b(1, 1) !== 32'h0050_0093) $display("FAIL stall_inst: got %h want 00500093", ev_b(1, 1)); else n_pass++;
        n_checks++; if (ev_cyc(1, 1) <= rel_cyc) $display("FAIL stall_early_delivery: got cyc %0d want > %0d", ev_cyc(1, 1), rel_cyc); else n_pass++;
        n_checks++; if (ev_a(1, 2) !== 32'h8) $display("FAIL stall_next_pc: got %h want 00000008", ev_a(1, 2)); else n_pass++;
        begin
            int dup = 0;
            foreach (evq[i]) if (evq[i].kind == 1 && evq[i].a == 32'h4) dup++;
            n_checks++; if (dup !== 1) $display("FAIL stall_dup_delivery: got %0d want 1", dup); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        lat_fixed = 3;
        do_reset();
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge clk);
            if (imem_req_IF && imem_addr_IF == 32'h0) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL redir_wait_req0: got %b want 1", found); else n_pass++;
        tick();
        redirect_IF = 1'b1; redirect_PC_IF = 32'h100;
        tick();
        redirect_IF = 1'b0;
        repeat (15) tick();
        n_checks++; if (ev_a(0, 1) !== 32'h100) $display("FAIL redir_req_addr: got %h want 00000100", ev_a(0, 1)); else n_pass++;
        n_checks++; if (ev_a(1, 0) !== 32'h100) $display("FAIL redir_pc_out: got %h want 00000100", ev_a(1, 0)); else n_pass++;
        n_checks++; if (ev_b(1, 0) !== mem_word(32'h100)) $display("FAIL redir_inst: got %h want %h", ev_b(1, 0), mem_word(32'h100)); else n_pass++;
        n_checks++; if (overlap_err !== 0) $display("FAIL redir_outstanding: got %0d overlaps want 0", overlap_err); else n_pass++;
    endtask

    task automatic test_flush_stall();
        bit found = 0;
        lat_fixed = 1;
        do_reset();
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (valid_out_IF === 1'b1) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL fs_wait_valid: got %b want 1", found); else n_pass++;
        stall_IF = 1'b1;
        tick();
        n_checks++; if (valid_out_IF !== 1'b1) $display("FAIL fs_stall_hold_valid: got %b want 1", valid_out_IF); else n_pass++;
        flush_IF = 1'b1;
        tick();
        n_checks++; if (valid_out_IF !== 1'b0) $display("FAIL fs_valid: got %b want 0", valid_out_IF); else n_pass++;
        n_checks++; if (Inst_out_IF !== 32'h13) $display("FAIL fs_inst: got %h want 00000013", Inst_out_IF); else n_pass++;
        n_checks++; if (PC_out_IF !== 32'h0) $display("FAIL fs_pc_hold: got %h want 00000000", PC_out_IF); else n_pass++;
        flush_IF = 1'b0;
        stall_IF = 1'b0;
    endtask

    task automatic test_wrap();
        lat_fixed = 1;
        do_reset();
        redirect_IF = 1'b1; redirect_PC_IF = 32'hFFFF_FFFC;
        tick();
        redirect_IF = 1'b0;
        repeat (12) tick();
        n_checks++; if (ev_a(0, 1) !== 32'hFFFF_FFFC) $display("FAIL wrap_req_top: got %h want fffffffc", ev_a(0, 1)); else n_pass++;
        n_checks++; if (ev_a(1, 0) !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top: got %h want fffffffc", ev_a(1, 0)); else n_pass++;
        n_checks++; if (ev_b(1, 0) !== mem_word(32'hFFFF_FFFC)) $display("FAIL wrap_inst_top: got %h want %h", ev_b(1, 0), mem_word(32'hFFFF_FFFC)); else n_pass++;
        n_checks++; if (ev_a(0, 2) !== 32'h0) $display("FAIL wrap_req_zero: got %h want 00000000", ev_a(0, 2)); else n_pass++;
        n_checks++; if (ev_a(1, 1) !== 32'h0) $display("FAIL wrap_pc_zero: got %h want 00000000", ev_a(1, 1)); else n_pass++;
    endtask

    // Reference: the delivered stream is consecutive word addresses, restarting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc = '0;
        int n_del = 0;
        lat_fixed = 0;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            stall_IF    = ($urandom_range(99) < 30);
            redirect_IF = ($urandom_range(99) < 4);
            redirect_PC_IF = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        stall_IF = 1'b0; redirect_IF = 1'b0;
        repeat (10) tick();
        foreach (evq[i]) begin
            if (evq[i].kind == 2) begin
                exp_pc = evq[i].a;
            end else if (evq[i].kind == 1) begin
                n_checks++; if (evq[i].a !== exp_pc) $display("FAIL rnd_pc_out@%0d: got %h want %h", evq[i].cyc, evq[i].a, exp_pc); else n_pass++;
                n_checks++; if (evq[i].b !== mem_word(exp_pc)) $display("FAIL rnd_inst@%0d: got %h want %h", evq[i].cyc, evq[i].b, mem_word(exp_pc)); else n_pass++;
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end else begin
                n_checks++; if (evq[i].a !== exp_pc) $display("FAIL rnd_req_addr@%0d: got %h want %h", evq[i].cyc, evq[i].a, exp_pc); else n_pass++;
            end
        end
        n_checks++; if (n_del < 20) $display("FAIL rnd_throughput: got %0d deliveries want >= 20", n_del); else n_pass++;
        n_checks++; if (overlap_err !== 0) $display("FAIL rnd_outstanding: got %0d overlaps want 0", overlap_err); else n_pass++;
    endtask

`ifdef IF_FETCH_CNT_EN
    task automatic test_fetch_cnt();
        bit done = 0;
        lat_fixed = 1;
        do_reset();
        n_checks++; if (fetch_cnt_IF !== 32'd0) $display("FAIL cnt_reset: got %0d want 0", fetch_cnt_IF); else n_pass++;
        flush_IF = 1'b1;
        tick();
        tick();
        flush_IF = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (n_of(1) == 5) begin
                stall_IF = 1'b1;
                done = 1;
            end
        end
        n_checks++; if (done !== 1'b1) $display("FAIL cnt_wait_5: got %b want 1", done); else n_pass++;
        tick();
        tick();
        n_checks++; if (fetch_cnt_IF !== 32'd5) $display("FAIL cnt_value: got %0d want 5", fetch_cnt_IF); else n_pass++;
        do_reset();
        n_checks++; if (fetch_cnt_IF !== 32'd0) $display("FAIL cnt_rst_clear: got %0d want 0", fetch_cnt_IF); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_random();
`ifdef IF_FETCH_CNT_EN
        test_fetch_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
